// File: rtl/mult_arbiter.sv
// Round-robin arbiter that shares one sequential shift-add multiplier among N_REQ requesters.
// Optional WAIT-state abort on a stuck multiplier when MULT_TIMEOUT_EN is defined.
module mult_arbiter #(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [N_REQ-1:0]         Req,
    input  logic [N_REQ*WIDTH-1:0]   ReqA,
    input  logic [N_REQ*WIDTH-1:0]   ReqB,
    output logic [N_REQ-1:0]         Gnt,
    output logic [N_REQ-1:0]         RspValid,
    output logic [2*WIDTH-1:0]       RspProduto,
    output logic                     RspErr,
    output logic                     Busy,
    output logic                     MulSt,
    output logic                     MulReset,
    output logic [WIDTH-1:0]         MulA,
    output logic [WIDTH-1:0]         MulB,
    input  logic                     MulIdle,
    input  logic                     MulDone,
    input  logic [2*WIDTH-1:0]       MulProduto
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned SW = IW + 1;
    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    logic [1:0]        state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic              seen_busy_q, seen_busy_d;
    logic [N_REQ-1:0]  gnt_d, rsp_valid_d;
    logic [PW-1:0]     rsp_prod_d;
    logic              rsp_err_d, busy_d, mul_st_d, mul_reset_d;
    logic [WIDTH-1:0]  mul_a_d, mul_b_d;

    logic              win_found_c;
    logic [IW-1:0]     win_idx_c;
    logic [SW-1:0]     scan_c;

    logic [WIDTH-1:0]  req_a_arr [N_REQ];
    logic [WIDTH-1:0]  req_b_arr [N_REQ];

`ifdef MULT_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]     cnt_q, cnt_d;
`else
    logic              unused_timeout_c;
    assign unused_timeout_c = ^(32'(TIMEOUT));
`endif

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_a_arr[g] = ReqA[g*WIDTH +: WIDTH];
        assign req_b_arr[g] = ReqB[g*WIDTH +: WIDTH];
    end

    // First set request at or after the pointer, wrapping past N_REQ-1 to 0
    always_comb begin
        win_found_c = 1'b0;
        win_idx_c   = '0;
        scan_c      = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            scan_c = SW'(ptr_q) + SW'(off);
            if (scan_c >= SW'(N_REQ)) begin
                scan_c = scan_c - SW'(N_REQ);
            end
            if (!win_found_c && Req[scan_c[IW-1:0]]) begin
                win_found_c = 1'b1;
                win_idx_c   = scan_c[IW-1:0];
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        seen_busy_d = seen_busy_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_prod_d  = RspProduto;
        rsp_err_d   = RspErr;
        mul_st_d    = 1'b0;
        mul_reset_d = 1'b0;
        mul_a_d     = MulA;
        mul_b_d     = MulB;
`ifdef MULT_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_found_c && MulIdle) begin
                    owner_d  = win_idx_c;
                    mul_a_d  = req_a_arr[win_idx_c];
                    mul_b_d  = req_b_arr[win_idx_c];
                    gnt_d    = ONE_HOT0 << win_idx_c;
                    mul_st_d = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                seen_busy_d = 1'b0;
`ifdef MULT_TIMEOUT_EN
                cnt_d       = '0;
`endif
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (!MulIdle) begin
                    seen_busy_d = 1'b1;
                end
                // A Done seen before the multiplier went busy belongs to the previous op
                if (MulDone && seen_busy_q) begin
                    rsp_prod_d  = MulProduto;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = ONE_HOT0 << owner_q;
                    state_d     = ST_RESP;
                end
`ifdef MULT_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    mul_reset_d = 1'b1;
                    rsp_prod_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = ONE_HOT0 << owner_q;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                ptr_d   = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            seen_busy_q <= 1'b0;
            Gnt         <= '0;
            RspValid    <= '0;
            RspProduto  <= '0;
            RspErr      <= 1'b0;
            Busy        <= 1'b0;
            MulSt       <= 1'b0;
            MulReset    <= 1'b1;
            MulA        <= '0;
            MulB        <= '0;
`ifdef MULT_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            seen_busy_q <= seen_busy_d;
            Gnt         <= gnt_d;
            RspValid    <= rsp_valid_d;
            RspProduto  <= rsp_prod_d;
            RspErr      <= rsp_err_d;
            Busy        <= busy_d;
            MulSt       <= mul_st_d;
            MulReset    <= mul_reset_d;
            MulA        <= mul_a_d;
            MulB        <= mul_b_d;
`ifdef MULT_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

endmodule
